// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode class enum, immediate format enum,
// base opcode constants and the opcode-to-class/format mapping helpers.
package decode_pkg;

   typedef enum logic [3:0] {
      CLS_LUI       = 4'd0,
      CLS_AUIPC     = 4'd1,
      CLS_JAL       = 4'd2,
      CLS_JALR      = 4'd3,
      CLS_BRANCH    = 4'd4,
      CLS_LOAD      = 4'd5,
      CLS_STORE     = 4'd6,
      CLS_OP_IMM    = 4'd7,
      CLS_OP_IMM_32 = 4'd8,
      CLS_OP        = 4'd9,
      CLS_OP_32     = 4'd10,
      CLS_SYSTEM    = 4'd11,
      CLS_FENCE     = 4'd12,
      CLS_ILLEGAL   = 4'd15
   } id_class_e;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_FENCE     = 7'b0001111;

   // Full 7-bit match, so any compressed encoding (bits[1:0] != 11) lands in ILLEGAL.
   function automatic id_class_e opcode_class(input logic [6:0] opc);
      id_class_e cls;
      case (opc)
         OPC_LUI:       cls = CLS_LUI;
         OPC_AUIPC:     cls = CLS_AUIPC;
         OPC_JAL:       cls = CLS_JAL;
         OPC_JALR:      cls = CLS_JALR;
         OPC_BRANCH:    cls = CLS_BRANCH;
         OPC_LOAD:      cls = CLS_LOAD;
         OPC_STORE:     cls = CLS_STORE;
         OPC_OP_IMM:    cls = CLS_OP_IMM;
         OPC_OP_IMM_32: cls = CLS_OP_IMM_32;
         OPC_OP:        cls = CLS_OP;
         OPC_OP_32:     cls = CLS_OP_32;
         OPC_SYSTEM:    cls = CLS_SYSTEM;
         OPC_FENCE:     cls = CLS_FENCE;
         default:       cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

   function automatic imm_fmt_e class_format(input id_class_e cls);
      imm_fmt_e fmt;
      case (cls)
         CLS_LUI, CLS_AUIPC:                     fmt = FMT_U;
         CLS_JAL:                                fmt = FMT_J;
         CLS_BRANCH:                             fmt = FMT_B;
         CLS_STORE:                              fmt = FMT_S;
         CLS_JALR, CLS_LOAD, CLS_OP_IMM,
         CLS_OP_IMM_32, CLS_SYSTEM, CLS_FENCE:   fmt = FMT_I;
         default:                                fmt = FMT_R;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/imm_generator.sv
// Combinational field and immediate extraction for one 32-bit instruction.
module imm_generator
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [31:0]     instr_i,
   output id_class_e       class_o,
   output logic            illegal_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [4:0]      rd_o,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      funct3_o,
   output logic [6:0]      funct7_o,
   output logic            rs1_used_o,
   output logic            rs2_used_o
);

   id_class_e cls;
   imm_fmt_e  fmt;

   // Classify the opcode, then derive register fields and the sign-extended immediate.
   always_comb begin
      cls       = opcode_class(instr_i[6:0]);
      fmt       = class_format(cls);
      class_o   = cls;
      illegal_o = (cls == CLS_ILLEGAL) || (instr_i[1:0] != 2'b11);
      funct3_o  = instr_i[14:12];
      funct7_o  = instr_i[31:25];
      rs1_o     = instr_i[19:15];

      rs1_used_o = !(cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_FENCE, CLS_ILLEGAL});
      rs2_used_o = cls inside {CLS_BRANCH, CLS_STORE, CLS_OP, CLS_OP_32};
      rs2_o      = rs2_used_o ? instr_i[24:20] : 5'd0;

      rd_o = instr_i[11:7];
      if (cls inside {CLS_STORE, CLS_BRANCH, CLS_FENCE, CLS_ILLEGAL}) begin
         rd_o = 5'd0;
      end

      imm_o = '0;
      case (fmt)
         FMT_I: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
         FMT_S: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         FMT_B: imm_o = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         FMT_U: imm_o = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'd0};
         FMT_J: imm_o = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: IF/ID handshake, one registered output stage,
// flush handling and an optional RAW scoreboard enabled by DECODE_SCOREBOARD_EN.
module instruction_decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 64,
   parameter int unsigned ILEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_pc,
   input  logic [ILEN-1:0] if_instruction,
   input  logic            flush,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [4:0]      id_rd,
   output logic [XLEN-1:0] id_imm,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7,
   output id_class_e       id_class,
   output logic            id_illegal,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd
);

   id_class_e       dec_class;
   logic            dec_illegal;
   logic [4:0]      dec_rs1, dec_rs2, dec_rd;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_funct3;
   logic [6:0]      dec_funct7;
   logic            dec_rs1_used, dec_rs2_used;

   logic            accept;
   logic            hazard_stall;

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [6:0]      funct7_q, funct7_d;
   id_class_e       class_q, class_d;
   logic            illegal_q, illegal_d;

   imm_generator #(
      .XLEN(XLEN)
   ) u_imm_generator (
      .instr_i    (if_instruction[31:0]),
      .class_o    (dec_class),
      .illegal_o  (dec_illegal),
      .rs1_o      (dec_rs1),
      .rs2_o      (dec_rs2),
      .rd_o       (dec_rd),
      .imm_o      (dec_imm),
      .funct3_o   (dec_funct3),
      .funct7_o   (dec_funct7),
      .rs1_used_o (dec_rs1_used),
      .rs2_used_o (dec_rs2_used)
   );

   // Upstream ready: output slot free or draining, no flush, no RAW hazard, not in reset.
   always_comb begin
      if_ready = !reset && (!valid_q || id_ready) && !flush && !hazard_stall;
      accept   = if_valid && if_ready;
   end

   // Output register next state: flush beats accept, accept beats plain handoff.
   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      imm_d     = imm_q;
      funct3_d  = funct3_q;
      funct7_d  = funct7_q;
      class_d   = class_q;
      illegal_d = illegal_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         pc_d      = if_pc;
         rs1_d     = dec_rs1;
         rs2_d     = dec_rs2;
         rd_d      = dec_rd;
         imm_d     = dec_imm;
         funct3_d  = dec_funct3;
         funct7_d  = dec_funct7;
         class_d   = dec_class;
         illegal_d = dec_illegal;
      end else if (valid_q && id_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output register with synchronous reset to all zeros.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         class_q   <= id_class_e'(4'd0);
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         imm_q     <= imm_d;
         funct3_q  <= funct3_d;
         funct7_q  <= funct7_d;
         class_q   <= class_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef DECODE_SCOREBOARD_EN
   logic [31:0] pend_q, pend_d;
   logic [31:0] set_mask, clr_mask;

   // Stall when a source register actually read by the incoming instruction is pending.
   always_comb begin
      hazard_stall = (dec_rs1_used && pend_q[dec_rs1]) || (dec_rs2_used && pend_q[dec_rs2]);
   end

   // Pending mask update: clears applied first so a same-cycle set of the same rd wins;
   // a flush only retires the bit owned by the instruction sitting in the output register.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (accept && (dec_rd != 5'd0)) begin
         set_mask[dec_rd] = 1'b1;
      end
      if (wb_valid) begin
         clr_mask[wb_rd] = 1'b1;
      end
      if (flush && valid_q) begin
         clr_mask[rd_q] = 1'b1;
      end
      pend_d    = (pend_q & ~clr_mask) | set_mask;
      pend_d[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end
`else
   logic unused_sb;

   assign hazard_stall = 1'b0;
   assign unused_sb    = ^{wb_valid, wb_rd, dec_rs1_used, dec_rs2_used};
`endif

   assign id_valid   = valid_q;
   assign id_pc      = pc_q;
   assign id_rs1     = rs1_q;
   assign id_rs2     = rs2_q;
   assign id_rd      = rd_q;
   assign id_imm     = imm_q;
   assign id_funct3  = funct3_q;
   assign id_funct7  = funct7_q;
   assign id_class   = class_q;
   assign id_illegal = illegal_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: spec-level reference model
// compared every cycle plus directed vectors with literal expectations.
module tb_instruction_decode_stage;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [63:0] if_pc = '0;
   logic [31:0] if_instruction = '0;
   logic        flush = 1'b0;
   logic        id_valid;
   logic        id_ready = 1'b1;
   logic [63:0] id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [63:0] id_imm;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
   id_class_e   id_class;
   logic        id_illegal;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;

   instruction_decode_stage #(
      .XLEN(64),
      .ILEN(32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .flush          (flush),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rd          (id_rd),
      .id_imm         (id_imm),
      .id_funct3      (id_funct3),
      .id_funct7      (id_funct7),
      .id_class       (id_class),
      .id_illegal     (id_illegal),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0]  cls;
      logic        ill;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        u1, u2;
   } dec_t;

   function automatic dec_t model_decode(input logic [31:0] ins);
      dec_t   d;
      byte    fmt;
      longint sv;
      fmt   = "N";
      d.cls = CLS_ILLEGAL;
      case (ins[6:0])
         7'h37: begin d.cls = CLS_LUI;       fmt = "U"; end
         7'h17: begin d.cls = CLS_AUIPC;     fmt = "U"; end
         7'h6F: begin d.cls = CLS_JAL;       fmt = "J"; end
         7'h67: begin d.cls = CLS_JALR;      fmt = "I"; end
         7'h63: begin d.cls = CLS_BRANCH;    fmt = "B"; end
         7'h03: begin d.cls = CLS_LOAD;      fmt = "I"; end
         7'h23: begin d.cls = CLS_STORE;     fmt = "S"; end
         7'h13: begin d.cls = CLS_OP_IMM;    fmt = "I"; end
         7'h1B: begin d.cls = CLS_OP_IMM_32; fmt = "I"; end
         7'h33: begin d.cls = CLS_OP;        fmt = "R"; end
         7'h3B: begin d.cls = CLS_OP_32;     fmt = "R"; end
         7'h73: begin d.cls = CLS_SYSTEM;    fmt = "I"; end
         7'h0F: begin d.cls = CLS_FENCE;     fmt = "I"; end
         default: ;
      endcase
      d.ill = (d.cls == CLS_ILLEGAL);
      sv = 0;
      case (fmt)
         "I": sv = $signed(ins[31:20]);
         "S": sv = $signed({ins[31:25], ins[11:7]});
         "B": sv = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
         "U": sv = $signed({ins[31:12], 12'h000});
         "J": sv = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
         default: sv = 0;
      endcase
      d.imm = sv;
      d.u2  = (fmt == "S") || (fmt == "B") || (fmt == "R");
      d.u1  = (fmt != "U") && (fmt != "J") && (d.cls != CLS_FENCE) && !d.ill;
      d.rs1 = ins[19:15];
      d.rs2 = d.u2 ? ins[24:20] : 5'd0;
      d.rd  = ((fmt == "S") || (fmt == "B") || (d.cls == CLS_FENCE) || d.ill) ? 5'd0 : ins[11:7];
      d.f3  = ins[14:12];
      d.f7  = ins[31:25];
      return d;
   endfunction

   bit          m_valid = 1'b0;
   bit          m_zero  = 1'b0;
   logic [63:0] m_pc    = '0;
   dec_t        m_dec;
`ifdef DECODE_SCOREBOARD_EN
   bit          pend [32];
`endif

   function automatic logic m_ready();
      dec_t d;
      logic hz;
      d  = model_decode(if_instruction);
      hz = 1'b0;
`ifdef DECODE_SCOREBOARD_EN
      hz = (d.u1 && pend[d.rs1]) || (d.u2 && pend[d.rs2]);
`endif
      return !reset && (!m_valid || id_ready) && !flush && !hz;
   endfunction

   always @(posedge clk) begin
      logic rdy;
      dec_t d;
      rdy = m_ready();
      d   = model_decode(if_instruction);
      if (reset) begin
         m_valid = 1'b0;
         m_zero  = 1'b1;
         m_pc    = '0;
         m_dec   = '{default: '0};
`ifdef DECODE_SCOREBOARD_EN
         foreach (pend[i]) pend[i] = 1'b0;
`endif
      end else begin
`ifdef DECODE_SCOREBOARD_EN
         if (wb_valid) pend[wb_rd] = 1'b0;
         if (flush && m_valid) pend[m_dec.rd] = 1'b0;
         if (if_valid && rdy && (d.rd != 5'd0)) pend[d.rd] = 1'b1;
`endif
         if (flush) begin
            m_valid = 1'b0;
         end else if (if_valid && rdy) begin
            m_valid = 1'b1;
            m_zero  = 1'b0;
            m_dec   = d;
            m_pc    = if_pc;
         end else if (m_valid && id_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("if_ready", if_ready, m_ready());
      chk("id_valid", id_valid, m_valid);
      if (m_valid || m_zero) begin
         chk("id_pc",      id_pc,      m_pc);
         chk("id_rs1",     id_rs1,     m_dec.rs1);
         chk("id_rs2",     id_rs2,     m_dec.rs2);
         chk("id_rd",      id_rd,      m_dec.rd);
         chk("id_imm",     id_imm,     m_dec.imm);
         chk("id_funct3",  id_funct3,  m_dec.f3);
         chk("id_funct7",  id_funct7,  m_dec.f7);
         chk("id_class",   id_class,   m_dec.cls);
         chk("id_illegal", id_illegal, m_dec.ill);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [31:0] ins, input logic [63:0] pc);
      bit ok;
      ok             = 1'b0;
      if_instruction = ins;
      if_pc          = pc;
      if_valid       = 1'b1;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (if_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      if_valid = 1'b0;
      chk("accept_wait", ok, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      if_valid       = 1'b1;
      if_instruction = 32'hFFF00293;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_ready", if_ready, 1'b0);
      chk("rst_id_valid", id_valid, 1'b0);
      chk("rst_id_pc",    id_pc,    64'h0);
      chk("rst_id_imm",   id_imm,   64'h0);
      reset    = 1'b0;
      if_valid = 1'b0;

      // ADDI x5,x0,-1
      send(32'hFFF00293, 64'h1000);
      chk("addi_valid", id_valid, 1'b1);
      chk("addi_class", id_class, CLS_OP_IMM);
      chk("addi_rd",    id_rd,    5'd5);
      chk("addi_imm",   id_imm,   64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_pc",    id_pc,    64'h1000);

      // SW x6,8(x2)
      send(32'h00612423, 64'h1004);
      chk("sw_class", id_class, CLS_STORE);
      chk("sw_rd",    id_rd,    5'd0);
      chk("sw_rs1",   id_rs1,   5'd2);
      chk("sw_rs2",   id_rs2,   5'd6);
      chk("sw_imm",   id_imm,   64'd8);

      // BEQ x1,x2,-4
      send(32'hFE208EE3, 64'h1008);
      chk("beq_class", id_class, CLS_BRANCH);
      chk("beq_imm",   id_imm,   64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_rd",    id_rd,    5'd0);

      // JAL x1,8
      send(32'h008000EF, 64'h100C);
      chk("jal_class", id_class, CLS_JAL);
      chk("jal_imm",   id_imm,   64'd8);
      chk("jal_rd",    id_rd,    5'd1);

      // LUI x10,0x80000
      send(32'h80000537, 64'h1010);
      chk("lui_imm", id_imm, 64'hFFFF_FFFF_8000_0000);
      chk("lui_rs2", id_rs2, 5'd0);

      // ADD x7,x3,x4
      send(32'h004183B3, 64'h1014);
      chk("add_class", id_class, CLS_OP);
      chk("add_imm",   id_imm,   64'd0);
      chk("add_rs2",   id_rs2,   5'd4);

      // Compressed-looking encoding
      send(32'h00000010, 64'h1018);
      chk("ill_flag",  id_illegal, 1'b1);
      chk("ill_class", id_class,   CLS_ILLEGAL);
      chk("ill_rd",    id_rd,      5'd0);

      // Backpressure: hold A for 3 cycles while B waits
      @(posedge clk);
      #1;
      id_ready = 1'b0;
      send(32'h00100413, 64'h2000);
      if_instruction = 32'h00200493;
      if_pc          = 64'h2004;
      if_valid       = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_if_ready", if_ready, 1'b0);
         chk("bp_id_pc",    id_pc,    64'h2000);
         chk("bp_id_valid", id_valid, 1'b1);
      end
      @(posedge clk);
      #1;
      id_ready = 1'b1;
      send(32'h00200493, 64'h2004);
      chk("bp_next_pc", id_pc, 64'h2004);

      // Flush coincident with an accept attempt
      if_instruction = 32'h00300593;
      if_pc          = 64'h3000;
      if_valid       = 1'b1;
      flush          = 1'b1;
      @(negedge clk);
      chk("fl_if_ready", if_ready, 1'b0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      if_valid = 1'b0;
      chk("fl_id_valid", id_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("fl_dropped", id_valid, 1'b0);

      // Reset while an instruction is held
      id_ready = 1'b0;
      send(32'h00001637, 64'h4000);
      chk("rh_held", id_valid, 1'b1);
      reset    = 1'b1;
      if_valid = 1'b1;
      @(negedge clk);
      chk("rh_if_ready", if_ready, 1'b0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      if_valid = 1'b0;
      id_ready = 1'b1;
      chk("rh_id_valid", id_valid, 1'b0);
      chk("rh_id_pc",    id_pc,    64'h0);

`ifdef DECODE_SCOREBOARD_EN
      // ADDI x5 then ADD x7,x5,x5 stalls until writeback of x5
      send(32'hFFF00293, 64'h5000);
      if_instruction = 32'h005283B3;
      if_pc          = 64'h5004;
      if_valid       = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("raw_stall", if_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      wb_valid = 1'b1;
      wb_rd    = 5'd5;
      @(negedge clk);
      chk("raw_wb_cycle", if_ready, 1'b0);
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      @(negedge clk);
      chk("raw_released", if_ready, 1'b1);
      @(posedge clk);
      #1;
      if_valid = 1'b0;
      chk("raw_accept_pc", id_pc, 64'h5004);

      // Same-cycle set and writeback of x5: set wins
      wb_valid = 1'b1;
      wb_rd    = 5'd5;
      send(32'hFFF00293, 64'h5008);
      wb_valid       = 1'b0;
      if_instruction = 32'h005283B3;
      if_pc          = 64'h500C;
      if_valid       = 1'b1;
      @(negedge clk);
      chk("set_wins_stall", if_ready, 1'b0);
      @(posedge clk);
      #1;
      wb_valid = 1'b1;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      send(32'h005283B3, 64'h500C);

      // Flush retires the held instruction's pending bit
      id_ready = 1'b0;
      send(32'h00100693, 64'h6000);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush          = 1'b0;
      id_ready       = 1'b1;
      if_instruction = 32'h00D68733;
      if_pc          = 64'h6004;
      if_valid       = 1'b1;
      @(negedge clk);
      chk("flush_clears_pend", if_ready, 1'b1);
      send(32'h00D68733, 64'h6004);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: if_valid in 1, if_ready out 1, if_pc in XLEN, if_instruction in ILEN; upstream IF/ID handshake.
REQ-006 SHALL have port: flush in 1; discard held and incoming instruction.
REQ-007 SHALL have ports: id_valid out 1, id_ready in 1; downstream ID/EX handshake.
REQ-008 SHALL have outputs: id_pc XLEN, id_rs1/id_rs2/id_rd 5 each, id_imm XLEN, id_funct3 3, id_funct7 7, id_class 4 (opcode class enum), id_illegal 1.
REQ-009 SHALL have ports: wb_valid in 1, wb_rd in 5; writeback retire notification.

Function
REQ-010 SHALL register decoded fields in one output stage; latency 1 cycle from accepted if_valid to id_valid.
REQ-011 SHALL assert if_ready = (!id_valid || id_ready) && !flush && !hazard_stall.
REQ-012 SHALL accept input when if_valid && if_ready; hold all id_* stable while id_valid && !id_ready.
REQ-013 SHALL clear id_valid on handoff (id_valid && id_ready) with no new accept in that cycle.
REQ-014 SHALL, on flush, clear id_valid next cycle and accept nothing that cycle; flush overrides simultaneous accept and handoff.
REQ-015 SHALL decode classes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_IMM_32, OP, OP_32, SYSTEM, FENCE; any other opcode -> class ILLEGAL, id_illegal=1.
REQ-016 SHALL flag id_illegal when instruction[1:0] != 2'b11 (compressed unsupported).
REQ-017 SHALL sign-extend immediates from bit 31 to XLEN: I, S, B (bit0=0), U (low 12 zero), J (bit0=0); R-type id_imm=0.
REQ-018 SHALL force id_rd=0 for STORE, BRANCH, FENCE and illegal; id_rs2=0 where rs2 unused.
REQ-019 SHALL pass id_pc = accepted if_pc unmodified.

Reset
REQ-020 SHALL, while reset=1 at posedge, set id_valid=0, all id_* data outputs=0, scoreboard=0.
REQ-021 SHALL hold if_ready=0 during reset; reset mid-handshake drops held instruction.

Configuration
REQ-022 SHALL compile RAW scoreboard only when DECODE_SCOREBOARD_EN is defined.
REQ-023 With DECODE_SCOREBOARD_EN: 32-bit pending mask; bit rd set on accept when rd!=0; cleared on wb_valid for wb_rd; simultaneous set/clear same rd -> set wins; bit 0 never set.
REQ-024 With DECODE_SCOREBOARD_EN: hazard_stall=1 when used rs1 or rs2 pending (combinational on if_instruction); flush clears only the bit set by the instruction still held in the output register.
REQ-025 Without DECODE_SCOREBOARD_EN: hazard_stall tied 0, wb_* ignored.

Structure
REQ-026 SHALL place id_class enum, opcode constants and immediate-format enum in shared package decode_pkg.
REQ-027 SHALL implement field/immediate extraction as combinational sub-module imm_generator; instruction_decode_stage owns handshake, output register, scoreboard.

Verification
REQ-028 ADDI x5,x0,-1 (0xFFF00293) at pc 0x1000, id_ready=1 -> next cycle id_valid=1, id_class=OP_IMM, id_rd=5, id_imm=0xFFFF_FFFF_FFFF_FFFF, id_pc=0x1000.
REQ-029 SW x6,8(x2) (0x00612423) -> id_class=STORE, id_rd=0, id_rs1=2, id_rs2=6, id_imm=8.
REQ-030 id_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, id_* unchanged; id_ready=1 -> next instruction appears one cycle later.
REQ-031 flush asserted same cycle as accept -> id_valid=0 next cycle, instruction dropped.
REQ-032 0x0000_0013 with bits[1:0]=00 substituted (0x0000_0010) -> id_illegal=1, id_class=ILLEGAL.
REQ-033 DECODE_SCOREBOARD_EN: ADDI x5 then ADD x7,x5,x5 -> if_ready=0 until wb_valid=1, wb_rd=5; accept next cycle.
